shifter_pipelined: RTL and testbench
====================================

Name: shifter_pipelined

Overview:
- Parametrised, pipelined barrel shifter. It is the successor to the single-cycle combinational right shifter.
- Supports four modes: logical left, logical right, arithmetic right, and rotate right.
- Built as a log2(N)-stage shift network with configurable register ranks and a valid/ready handshake on both sides.
- Sits between the ALU operand muxes and the writeback path, with a throughput of one operation per cycle.

Parameters:
- N, 32, data width in bits; must be a power of two and at least 2.
- STAGES_PER_REG, 2, number of shift stages (shifts by 1, 2, 4, …) between register ranks; legal range is 1 to $clog2(N).
- L (localparam), ceil($clog2(N)/STAGES_PER_REG), number of register ranks; this equals the latency. Default is 3.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a new operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- in  input  N  operand.
- shamt  input  $clog2(N)  shift amount, range 0 to N-1.
- op  input  2  mode: 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out  output  N  result.

Behaviour:
- Reset (sync, active-high): on the rising edge with rst=1:
  - every rank valid bit clears to 0, and all data, shamt and op registers clear to 0;
  - out_valid=0 and out=0 on the following cycle;
  - in_ready=1 while out_valid=0.
- Reset mid-operation: all in-flight operations are discarded and none emerges afterward.
- Stage k (k = 0 to $clog2(N)-1) conditionally applies a shift of 2^k when shamt[k]=1; the order is LSB stage first.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the operand's original bit N-1, carried down the pipe with the data.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Register ranks:
  - A register rank follows every STAGES_PER_REG stages; the last rank may hold fewer stages.
  - Each rank holds data, the remaining shamt bits, op, the sign bit, and a valid bit.
  - out is driven directly from the final rank; there is no combinational path from in to out.
- Latency: an operation accepted on cycle t (in_valid & in_ready) appears with out_valid=1 on cycle t+L, provided no stall occurs.
- Global advance:
  - advance = !out_valid | out_ready, and in_ready = advance.
  - When advance=1, every rank loads from its predecessor, and rank 0 loads in_valid (its valid bit) together with the operand.
  - When advance=0, all ranks hold, and out and out_valid stay stable.
- Bubbles: ranks with valid=0 still shift, but their data is don't-care. out is meaningful only when out_valid=1.
- Throughput: back-to-back accepts every cycle while out_ready=1, with results emitted in order and none dropped or duplicated.
- Simultaneous out_ready=1 and in_valid=1 while the pipe is full: the output retires and the input is accepted on the same edge.
- Stalls:
  - If out_ready=0 while out_valid=1, in_ready drops combinationally the same cycle.
  - in_valid with in_ready=0 is not consumed; the upstream holds its inputs.
- shamt=0 passes the operand through unchanged in all modes.
- Maximum shift amount N-1:
  - SLL gives {in[0], zeros}.
  - SRL gives {zeros, in[N-1]}.
  - SRA gives all bits equal to in[N-1].
  - ROR gives {in[N-2:0], in[N-1]}.
- op and shamt are captured with the operand, so later changes do not affect in-flight items.

Test Plan:
- Directed modes (N=32, STAGES_PER_REG=2, out_ready=1):
  - SRA 0x8000_0000 by 4 gives 0xF800_0000.
  - SRL 0xFFFF_FFFF by 31 gives 0x0000_0001.
  - SLL 0x0000_0001 by 31 gives 0x8000_0000.
  - ROR 0x0000_0001 by 1 gives 0x8000_0000.
  - Each result appears with out_valid exactly 3 cycles after acceptance.
- Pass-through: each op with shamt=0 and in=0xDEAD_BEEF gives out=0xDEAD_BEEF.
- Streaming plus backpressure:
  - Stimulus: 8 back-to-back SRL ops with in=0xFFFF_FFFF and shamt=0 to 7; hold out_ready=0 for 4 cycles starting when the first result is valid.
  - Required response: out holds 0xFFFF_FFFF and in_ready=0 during the stall; afterwards results 0xFFFF_FFFF through 0x01FF_FFFF arrive in order with none lost.
- Reset mid-flight: accept 2 ops, then assert rst for 1 cycle. out_valid must stay 0 for the next 5 cycles and in_ready=1 the cycle after reset.
- Exhaustive self-check: random in, all 32 shamt values, all 4 ops, with random out_ready toggling. Compare against a software model; 0 mismatches.
- Parameter sweep: N=8 with STAGES_PER_REG=1 (L=3) and N=16 with STAGES_PER_REG=4 (L=1). Latency and results must match the model.

Source files
------------

// File: rtl/shifter_pipelined.sv
// -----------------------------------------------------------------------------
// shifter_pipelined
//
// Pipelined barrel shifter. It is a log2(N)-stage shift network. Stage k
// shifts by 2^k when shamt[k] is set, and the LSB stage comes first. A
// register rank follows every STAGES_PER_REG stages, so the latency is
// L = ceil(log2(N) / STAGES_PER_REG) cycles. A single global advance
// signal moves every rank at once, which gives one operation per cycle
// when downstream is ready.
//
// Modes (op): 00 SLL, 01 SRL, 10 SRA, 11 ROR.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation presented upstream
//   in_ready   operation accepted this cycle (= advance)
//   in         operand, N bits
//   shamt      shift amount, $clog2(N) bits
//   op         shift mode, 2 bits
//   out_valid  result valid (final rank valid bit)
//   out_ready  downstream accepts result
//   out        result, N bits, driven straight from the final rank
// -----------------------------------------------------------------------------
module shifter_pipelined #(
    parameter int N              = 32,
    parameter int STAGES_PER_REG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = LOGN;
    localparam int L    = (LOGN + STAGES_PER_REG - 1) / STAGES_PER_REG;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One conditional shift-by-2^k stage. sg is the operand's original MSB.
    // It travels with the data, so SRA fill stays correct in later ranks.
    function automatic logic [N-1:0] shift_stage(
        input logic [N-1:0] d,
        input logic [SW-1:0] s,
        input int            k,
        input logic [1:0]    o,
        input logic          sg
    );
        logic [SW-1:0] sel;
        logic [N-1:0]  fill;
        logic [N-1:0]  r;
        int            sh;
        sel  = s >> k;
        sh   = 1 << k;
        fill = ~({N{1'b1}} >> sh);
        r    = d;
        if (sel[0]) begin
            case (o)
                OP_SLL:  r = d << sh;
                OP_SRL:  r = d >> sh;
                OP_SRA:  r = (d >> sh) | (sg ? fill : '0);
                OP_ROR:  r = (d >> sh) | (d << (N - sh));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // All the stages that sit in front of register rank rk. The last rank
    // may hold fewer than STAGES_PER_REG stages.
    function automatic logic [N-1:0] rank_shift(
        input logic [N-1:0]  d,
        input logic [SW-1:0] s,
        input int            rk,
        input logic [1:0]    o,
        input logic          sg
    );
        logic [N-1:0] r;
        int           k;
        r = d;
        for (int j = 0; j < STAGES_PER_REG; j++) begin
            k = rk * STAGES_PER_REG + j;
            if (k < LOGN) r = shift_stage(r, s, k, o, sg);
        end
        return r;
    endfunction

    logic [N-1:0]  data_p  [L];
    logic [SW-1:0] shamt_p [L];
    logic [1:0]    op_p    [L];
    logic          sign_p  [L];
    logic          vld_p   [L];
    logic [N-1:0]  nxt_p   [L];
    logic          advance;

    assign out_valid = vld_p[L-1];
    assign out       = data_p[L-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Combinational shift network in front of each rank.
    always_comb begin
        nxt_p[0] = rank_shift(in, shamt, 0, op, in[N-1]);
        for (int r = 1; r < L; r++) begin
            nxt_p[r] = rank_shift(data_p[r-1], shamt_p[r-1], r, op_p[r-1], sign_p[r-1]);
        end
    end

    // Register ranks p0..p(L-1). Every rank moves together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < L; r++) begin
                data_p[r]  <= '0;
                shamt_p[r] <= '0;
                op_p[r]    <= '0;
                sign_p[r]  <= 1'b0;
                vld_p[r]   <= 1'b0;
            end
        end else if (advance) begin
            data_p[0]  <= nxt_p[0];
            shamt_p[0] <= shamt;
            op_p[0]    <= op;
            sign_p[0]  <= in[N-1];
            vld_p[0]   <= in_valid;
            for (int r = 1; r < L; r++) begin
                data_p[r]  <= nxt_p[r];
                shamt_p[r] <= shamt_p[r-1];
                op_p[r]    <= op_p[r-1];
                sign_p[r]  <= sign_p[r-1];
                vld_p[r]   <= vld_p[r-1];
            end
        end
    end

endmodule

// File: tb/tb_shifter_pipelined.sv
module tb_shifter_pipelined;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance: N=32, STAGES_PER_REG=2, L=3
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] din, dout;
    logic [4:0]  shamt;
    logic [1:0]  op;

    // Sweep instance A: N=8, STAGES_PER_REG=1, L=3
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_din, a_dout;
    logic [2:0]  a_shamt;
    logic [1:0]  a_op;

    // Sweep instance B: N=16, STAGES_PER_REG=4, L=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_din, b_dout;
    logic [3:0]  b_shamt;
    logic [1:0]  b_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shifter_pipelined #(.N(32), .STAGES_PER_REG(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in(din), .shamt(shamt), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out(dout)
    );

    shifter_pipelined #(.N(8), .STAGES_PER_REG(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in(a_din), .shamt(a_shamt), .op(a_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_dout)
    );

    shifter_pipelined #(.N(16), .STAGES_PER_REG(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in(b_din), .shamt(b_shamt), .op(b_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_dout)
    );

    // Whole-word reference shifter for an n-bit datapath (n <= 32).
    function automatic logic [31:0] model(input logic [31:0] x, input int s,
                                          input logic [1:0] o, input int n);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        x = x & mask;
        case (o)
            2'b00:   r = (x << s) & mask;
            2'b01:   r = x >> s;
            2'b10: begin
                r = x >> s;
                if (x[n-1]) r = r | (mask & ~(mask >> s));
            end
            default: r = ((x >> s) | ((s == 0) ? 32'd0 : (x << (n - s)))) & mask;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (dout !== 32'h0) begin
            errors++; $display("FAIL reset_out got=%h want=00000000", dout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_modes();
        logic [31:0] vin  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        logic [4:0]  vsh  [4] = '{5'd4, 5'd31, 5'd31, 5'd1};
        logic [1:0]  vop  [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic [31:0] vexp [4] = '{32'hF800_0000, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; din = vin[v]; shamt = vsh[v]; op = vop[v];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL mode%0d_in_ready got=%b want=1", v, in_ready);
            end
            step();
            in_valid = 1'b0; din = 32'h0; shamt = 5'd0; op = 2'b00;
            for (int c = 1; c <= 3; c++) begin
                if (c < 3) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++; $display("FAIL mode%0d_early_valid cycle=%0d got=%b want=0", v, c, out_valid);
                    end
                end else begin
                    checks++;
                    if (out_valid !== 1'b1 || dout !== vexp[v]) begin
                        errors++;
                        $display("FAIL mode%0d_result valid=%b got=%h want=%h", v, out_valid, dout, vexp[v]);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_passthrough();
        int waited;
        out_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            in_valid = 1'b1; din = 32'hDEAD_BEEF; shamt = 5'd0; op = 2'(o);
            step();
            in_valid = 1'b0;
            waited = 0;
            while (out_valid !== 1'b1 && waited < 10) begin
                step();
                waited++;
            end
            checks++;
            if (out_valid !== 1'b1 || dout !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL pass_op%0d valid=%b got=%h want=deadbeef", o, out_valid, dout);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, recv = 0, stall_left = 0, cyc = 0;
        bit stall_done = 0;
        while (recv < 8 && cyc < 60) begin
            if (!stall_done && out_valid === 1'b1) begin
                stall_left = 4;
                stall_done = 1;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 8);
            din = 32'hFFFF_FFFF; shamt = 5'(sent); op = 2'b01;
            #1;
            if (stall_left > 0) begin
                checks++;
                if (out_valid !== 1'b1 || dout !== 32'hFFFF_FFFF || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b out=%h in_ready=%b want 1/ffffffff/0",
                             out_valid, dout, in_ready);
                end
                stall_left--;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (dout !== (32'hFFFF_FFFF >> recv)) begin
                    errors++;
                    $display("FAIL stream_%0d got=%h want=%h", recv, dout, 32'hFFFF_FFFF >> recv);
                end
                recv++;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (recv != 8) begin
            errors++; $display("FAIL stream_count got=%0d want=8", recv);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_extra got_valid=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; din = 32'h1234_5678; shamt = 5'(i + 1); op = 2'b00;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready got=%b want=1", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_valid cycle=%0d got=%b want=0", c, out_valid);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] cur, want;
        int sent = 0, recv = 0, cyc = 0;
        cur = $urandom;
        while (recv < 128 && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 128);
            din = cur; shamt = 5'(sent / 4); op = 2'(sent % 4);
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                checks++;
                if (dout !== want) begin
                    errors++; $display("FAIL random_%0d got=%h want=%h", recv, dout, want);
                end
                recv++;
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(cur, sent / 4, 2'(sent % 4), 32));
                sent++;
                cur = $urandom;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (recv != 128) begin
            errors++; $display("FAIL random_count got=%0d want=128", recv);
        end
        step();
    endtask

    task automatic test_sweep();
        logic [31:0] xa, xb, wa, wb;
        int lat_a, lat_b;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            for (int o = 0; o < 4; o++) begin
                xa = $urandom; xb = $urandom;
                a_din = xa[7:0];  a_shamt = 3'(s % 8); a_op = 2'(o); a_in_valid = 1'b1;
                b_din = xb[15:0]; b_shamt = 4'(s);     b_op = 2'(o); b_in_valid = 1'b1;
                wa = model({24'd0, xa[7:0]}, s % 8, 2'(o), 8);
                wb = model({16'd0, xb[15:0]}, s, 2'(o), 16);
                step();
                a_in_valid = 1'b0; b_in_valid = 1'b0;
                lat_a = 0; lat_b = 0;
                for (int c = 1; c <= 6; c++) begin
                    if (a_out_valid === 1'b1 && lat_a == 0) begin
                        lat_a = c;
                        checks++;
                        if (a_dout !== wa[7:0]) begin
                            errors++; $display("FAIL n8_s%0d_op%0d got=%h want=%h", s % 8, o, a_dout, wa[7:0]);
                        end
                    end
                    if (b_out_valid === 1'b1 && lat_b == 0) begin
                        lat_b = c;
                        checks++;
                        if (b_dout !== wb[15:0]) begin
                            errors++; $display("FAIL n16_s%0d_op%0d got=%h want=%h", s, o, b_dout, wb[15:0]);
                        end
                    end
                    step();
                end
                checks++;
                if (lat_a != 3) begin
                    errors++; $display("FAIL n8_latency got=%0d want=3", lat_a);
                end
                checks++;
                if (lat_b != 1) begin
                    errors++; $display("FAIL n16_latency got=%0d want=1", lat_b);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; din = '0; shamt = '0; op = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_din = '0; a_shamt = '0; a_op = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_din = '0; b_shamt = '0; b_op = '0;
        test_reset();
        test_modes();
        test_passthrough();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
